// File: rtl/sift_pkg.sv
// Shared constants and FSM state encoding for the frame sifting controller.
package sift_pkg;

  localparam int unsigned FRAME_W         = 80;
  localparam int unsigned LEN_W           = 7;
  localparam int unsigned KEY_LEN_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    ISSUE,
    CHECK,
    OUTPUT
  } state_e;

endpackage

// File: rtl/key_accum.sv
// One party's raw-key register: masks the compacted sifter word to its length
// and inserts it at the current fill position, dropping bits past the key end.
module key_accum
  import sift_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_LEN_DEFAULT,
  parameter int unsigned ACC_W = $clog2(KEY_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_append,
  input  logic [FRAME_W-1:0] i_data,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [ACC_W-1:0]   i_pos,
  output logic [KEY_W-1:0]   o_key
);

  logic [FRAME_W-1:0] w_mask;
  logic [KEY_W-1:0]   w_ins;
  logic [KEY_W-1:0]   r_key;

  // Sifter bits at index >= len are don't-care; the shift drops overflow.
  always_comb begin
    w_mask = '1;
    if (32'(i_len) < FRAME_W) w_mask = ~({FRAME_W{1'b1}} << i_len);
    w_ins = KEY_W'(i_data & w_mask) << i_pos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_key <= '0;
    else if (i_clear)  r_key <= '0;
    else if (i_append) r_key <= r_key | w_ins;
  end

  assign o_key = r_key;

endmodule

// File: rtl/sift_frame_ctrl.sv
// Per-frame sifting sequencer: issues frames to the external sifter, checks the
// returned lengths and accumulates sender/receiver raw keys for hand-off.
module sift_frame_ctrl
  import sift_pkg::*;
#(
  parameter int unsigned KEY_LEN = KEY_LEN_DEFAULT,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned ACC_W  = $clog2(KEY_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic [FRAME_W-1:0] s_sifted,
  input  logic [FRAME_W-1:0] s_svalid,
  input  logic [FRAME_W-1:0] r_sifted,
  input  logic [FRAME_W-1:0] r_svalid,
  output logic [FRAME_W-1:0] sift_s_sifted,
  output logic [FRAME_W-1:0] sift_s_svalid,
  output logic [FRAME_W-1:0] sift_r_sifted,
  output logic [FRAME_W-1:0] sift_r_svalid,
  input  logic [FRAME_W-1:0] sift_s_key,
  input  logic [FRAME_W-1:0] sift_r_key,
  input  logic [LEN_W-1:0]   sift_s_len,
  input  logic [LEN_W-1:0]   sift_r_len,
  output logic               key_valid,
  input  logic               key_ready,
  output logic [KEY_LEN-1:0] key_sender,
  output logic [KEY_LEN-1:0] key_receiver,
  output logic [ACC_W-1:0]   acc_len,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               busy
);

  localparam logic [ACC_W:0] FULL = (ACC_W + 1)'(KEY_LEN);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_frame_ready;
  logic               r_key_valid;
  logic               r_busy;
  logic [ACC_W-1:0]   r_acc_len;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CNT_W-1:0]   r_mismatch_cnt;
  logic [FRAME_W-1:0] r_s_sifted, r_s_svalid, r_r_sifted, r_r_svalid;
  logic [ACC_W:0]     w_sum;
  logic               w_hs, w_len_eq, w_append, w_clear;

  always_comb begin
    w_hs        = (r_state == ACCEPT) && frame_valid;
    w_len_eq    = (sift_s_len == sift_r_len);
    w_append    = (r_state == CHECK) && w_len_eq && (sift_s_len != '0);
    w_clear     = (r_state == OUTPUT) && key_ready;
    w_sum       = (ACC_W + 1)'(r_acc_len) + (ACC_W + 1)'(sift_s_len);
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = ACCEPT;
      ACCEPT:  if (frame_valid) w_state_nxt = ISSUE;
               else if (!enable) w_state_nxt = IDLE;
      ISSUE:   w_state_nxt = CHECK;
      CHECK:   w_state_nxt = (w_append && (w_sum >= FULL)) ? OUTPUT : ACCEPT;
      OUTPUT:  if (key_ready) w_state_nxt = enable ? ACCEPT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_frame_ready  <= 1'b0;
      r_key_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_acc_len      <= '0;
      r_frame_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_s_sifted     <= '0;
      r_s_svalid     <= '0;
      r_r_sifted     <= '0;
      r_r_svalid     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_ready <= (w_state_nxt == ACCEPT);
      r_key_valid   <= (w_state_nxt == OUTPUT);
      r_busy        <= (w_state_nxt != IDLE);
      if (w_hs) begin
        r_s_sifted <= s_sifted;
        r_s_svalid <= s_svalid;
        r_r_sifted <= r_sifted;
        r_r_svalid <= r_svalid;
        if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if ((r_state == CHECK) && !w_len_eq && (r_mismatch_cnt != '1))
        r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
      if (w_clear)       r_acc_len <= '0;
      else if (w_append) r_acc_len <= (w_sum >= FULL) ? ACC_W'(KEY_LEN) : ACC_W'(w_sum);
    end
  end

  key_accum #(.KEY_W(KEY_LEN), .ACC_W(ACC_W)) u_acc_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_append (w_append),
    .i_data   (sift_s_key),
    .i_len    (sift_s_len),
    .i_pos    (r_acc_len),
    .o_key    (key_sender)
  );

  key_accum #(.KEY_W(KEY_LEN), .ACC_W(ACC_W)) u_acc_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_append (w_append),
    .i_data   (sift_r_key),
    .i_len    (sift_r_len),
    .i_pos    (r_acc_len),
    .o_key    (key_receiver)
  );

  assign frame_ready   = r_frame_ready;
  assign key_valid     = r_key_valid;
  assign busy          = r_busy;
  assign acc_len       = r_acc_len;
  assign frame_cnt     = r_frame_cnt;
  assign mismatch_cnt  = r_mismatch_cnt;
  assign sift_s_sifted = r_s_sifted;
  assign sift_s_svalid = r_s_svalid;
  assign sift_r_sifted = r_r_sifted;
  assign sift_r_svalid = r_r_svalid;

endmodule

// File: tb/tb_sift_frame_ctrl.sv
// Bench for sift_frame_ctrl: a behavioural sifter plus a bit-list key model,
// directed corner cases followed by randomized frames.
module tb_sift_frame_ctrl;
  import sift_pkg::*;

  localparam int unsigned KL = 256;
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 16;

  logic               clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic               frame_valid = 1'b0, key_ready = 1'b0;
  logic [FRAME_W-1:0] s_sifted = '0, s_svalid = '0, r_sifted = '0, r_svalid = '0;
  logic [FRAME_W-1:0] sift_s_key = '0, sift_r_key = '0;
  logic [LEN_W-1:0]   sift_s_len = '0, sift_r_len = '0;
  logic               frame_ready, key_valid, busy;
  logic [FRAME_W-1:0] sift_s_sifted, sift_s_svalid, sift_r_sifted, sift_r_svalid;
  logic [KL-1:0]      key_sender, key_receiver;
  logic [AW-1:0]      acc_len;
  logic [CW-1:0]      frame_cnt, mismatch_cnt;

  int checks = 0, failures = 0;
  logic [KL-1:0] m_s, m_r;
  int m_len, m_fc, m_mc;

  sift_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .s_sifted(s_sifted), .s_svalid(s_svalid), .r_sifted(r_sifted), .r_svalid(r_svalid),
    .sift_s_sifted(sift_s_sifted), .sift_s_svalid(sift_s_svalid),
    .sift_r_sifted(sift_r_sifted), .sift_r_svalid(sift_r_svalid),
    .sift_s_key(sift_s_key), .sift_r_key(sift_r_key),
    .sift_s_len(sift_s_len), .sift_r_len(sift_r_len),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_sender(key_sender), .key_receiver(key_receiver),
    .acc_len(acc_len), .frame_cnt(frame_cnt), .mismatch_cnt(mismatch_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int popcnt(input logic [FRAME_W-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < FRAME_W; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [FRAME_W-1:0] compact(input logic [FRAME_W-1:0] d,
                                                 input logic [FRAME_W-1:0] m);
    logic [FRAME_W-1:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 0; i < FRAME_W; i++) if (m[i]) begin r[k] = d[i]; k++; end
    return r;
  endfunction

  // Garbage above the valid length exercises the masking in the design.
  function automatic logic [FRAME_W-1:0] dirty(input logic [FRAME_W-1:0] r, input int n);
    logic [FRAME_W-1:0] j, o;
    j = {16'($urandom()), $urandom(), $urandom()};
    o = r;
    for (int i = n; i < FRAME_W; i++) o[i] = j[i];
    return o;
  endfunction

  // External sifter: registered, one-cycle latency.
  always @(posedge clk) begin
    sift_s_key <= dirty(compact(sift_s_sifted, sift_s_svalid), popcnt(sift_s_svalid));
    sift_r_key <= dirty(compact(sift_r_sifted, sift_r_svalid), popcnt(sift_r_svalid));
    sift_s_len <= LEN_W'(popcnt(sift_s_svalid));
    sift_r_len <= LEN_W'(popcnt(sift_r_svalid));
  end

  task automatic check(input string tag, input logic [KL-1:0] obs, input logic [KL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = '0; m_r = '0; m_len = 0; m_fc = 0; m_mc = 0;
  endtask

  task automatic model_frame(input logic [FRAME_W-1:0] ss, input logic [FRAME_W-1:0] sv,
                             input logic [FRAME_W-1:0] rs, input logic [FRAME_W-1:0] rv);
    int ns, nr, ks, kr;
    ns = popcnt(sv);
    nr = popcnt(rv);
    if (m_fc < 65535) m_fc++;
    if (ns != nr) begin
      if (m_mc < 65535) m_mc++;
    end else begin
      ks = m_len;
      kr = m_len;
      for (int i = 0; i < FRAME_W; i++) begin
        if (sv[i]) begin if (ks < KL) m_s[ks] = ss[i]; ks++; end
        if (rv[i]) begin if (kr < KL) m_r[kr] = rs[i]; kr++; end
      end
      m_len = (m_len + ns > KL) ? KL : m_len + ns;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, KL'(frame_ready), '0);
    check({tag, "_kvalid"}, KL'(key_valid), '0);
    check({tag, "_busy"}, KL'(busy), '0);
    check({tag, "_acc"}, KL'(acc_len), '0);
    check({tag, "_fcnt"}, KL'(frame_cnt), '0);
    check({tag, "_mcnt"}, KL'(mismatch_cnt), '0);
    check({tag, "_keys"}, key_sender | key_receiver, '0);
    check({tag, "_ops"}, KL'(sift_s_sifted | sift_s_svalid | sift_r_sifted | sift_r_svalid), '0);
  endtask

  task automatic send(input logic [FRAME_W-1:0] ss, input logic [FRAME_W-1:0] sv,
                      input logic [FRAME_W-1:0] rs, input logic [FRAME_W-1:0] rv,
                      input bit drop_en);
    int t;
    @(negedge clk);
    s_sifted = ss; s_svalid = sv; r_sifted = rs; r_svalid = rv;
    frame_valid = 1'b1;
    t = 0;
    while (!frame_ready && t < 40) begin @(negedge clk); t++; end
    check("ready_wait", KL'(frame_ready), KL'(1));
    if (!frame_ready) begin frame_valid = 1'b0; return; end
    @(negedge clk);
    frame_valid = 1'b0;
    model_frame(ss, sv, rs, rv);
    check("fcnt", KL'(frame_cnt), KL'(m_fc));
    check("op_s", KL'(sift_s_sifted), KL'(ss));
    check("ready_issue", KL'(frame_ready), '0);
    if (drop_en) enable = 1'b0;
    @(negedge clk);
    check("ready_check", KL'(frame_ready), '0);
    @(negedge clk);
    check("acc_len", KL'(acc_len), KL'(m_len));
    check("mcnt", KL'(mismatch_cnt), KL'(m_mc));
    check("kvalid", KL'(key_valid), KL'(m_len == KL));
    check("ready_post", KL'(frame_ready), KL'(m_len != KL));
    check("key_s", key_sender, m_s);
    check("key_r", key_receiver, m_r);
  endtask

  task automatic release_key(input int hold);
    for (int i = 0; i < hold; i++) begin
      check("bp_kvalid", KL'(key_valid), KL'(1));
      check("bp_ready", KL'(frame_ready), '0);
      check("bp_key_s", key_sender, m_s);
      check("bp_acc", KL'(acc_len), KL'(KL));
      @(negedge clk);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    m_s = '0; m_r = '0; m_len = 0;
    check("rel_acc", KL'(acc_len), '0);
    check("rel_kvalid", KL'(key_valid), '0);
    check("rel_ready", KL'(frame_ready), KL'(enable));
    check("rel_keys", key_sender | key_receiver, '0);
  endtask

  initial begin
    logic [FRAME_W-1:0] a5, ones, ss, sv, rs, rv;
    logic [15:0] top16;
    int guard;
    a5 = {10{8'hA5}};
    ones = '1;
    model_reset();

    repeat (3) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", KL'(frame_ready), '0);
    enable = 1'b1;
    @(negedge clk);
    check("accept_ready", KL'(frame_ready), KL'(1));
    check("accept_busy", KL'(busy), KL'(1));

    for (int f = 0; f < 4; f++) send(a5, ones, a5, ones, 1'b0);
    top16 = key_sender[255:240];
    check("key_top16", KL'(top16), KL'(16'hA5A5));
    check("fcnt4", KL'(frame_cnt), KL'(4));
    release_key(10);

    send({$urandom(), $urandom(), $urandom()}, 80'hF, {$urandom(), $urandom(), $urandom()}, 80'h7, 1'b0);
    check("mcnt1", KL'(mismatch_cnt), KL'(1));
    send({$urandom(), $urandom(), $urandom()}, '0, {$urandom(), $urandom(), $urandom()}, '0, 1'b0);
    check("zero_len_acc", KL'(acc_len), '0);

    send({$urandom(), $urandom(), $urandom()}, 80'hFFFF, {$urandom(), $urandom(), $urandom()}, 80'hFFFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dis_ready", KL'(frame_ready), '0);
      check("dis_busy", KL'(busy), '0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("reen_ready", KL'(frame_ready), KL'(1));

    for (int f = 0; f < 40; f++) begin
      ss = {16'($urandom()), $urandom(), $urandom()};
      rs = {16'($urandom()), $urandom(), $urandom()};
      sv = {16'($urandom()), $urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) sv = '0;
      rv = ($urandom_range(0, 3) == 0) ? {16'($urandom()), $urandom(), $urandom()} : sv;
      send(ss, sv, rs, rv, 1'b0);
      if (key_valid) release_key(int'($urandom_range(0, 3)));
    end

    guard = 0;
    while (!key_valid && guard < 8) begin send(a5, ones, ~a5, ones, 1'b0); guard++; end
    check("fill_kvalid", KL'(key_valid), KL'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", KL'(frame_ready), KL'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sift_frame_ctrl.md
Name: sift_frame_ctrl

Overview:
- Sequences the per-frame sifting datapath for both parties and accumulates the compacted sifted bits into fixed-length raw keys.
- Accepts 80-bit sender/receiver frames over a valid/ready handshake and issues each one to the external sifter, whose outputs are registered with one-cycle latency.
- Checks the returned lengths, then appends or discards the frame.
- When KEY_LEN bits are accumulated, presents sender and receiver keys together to the downstream error-estimation stage.

Parameters:
- FRAME_W, 80: bits per frame / per sifter operand.
- LEN_W, 7: width of sifter length results.
- KEY_LEN, 256: bits per output key.
- ACC_W, 9: accumulator count width, clog2(KEY_LEN+1).
- CNT_W, 16: width of statistics counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  allow frame acceptance.
- frame_valid  in  1  frame offered.
- frame_ready  out  1  frame accepted when valid&ready.
- s_sifted, s_svalid, r_sifted, r_svalid  in  FRAME_W each  frame bits and sift masks.
- sift_s_sifted, sift_s_svalid, sift_r_sifted, sift_r_svalid  out  FRAME_W each  registered sifter operands.
- sift_s_key, sift_r_key  in  FRAME_W  compacted bits from sifter.
- sift_s_len, sift_r_len  in  LEN_W  compacted lengths from sifter.
- key_valid  out  1  key available.
- key_ready  in  1  downstream accepts key.
- key_sender, key_receiver  out  KEY_LEN  key bits; bit 0 is the oldest.
- acc_len  out  ACC_W  bits currently accumulated.
- frame_cnt, mismatch_cnt  out  CNT_W  frames accepted / frames discarded for length mismatch; both saturate.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs and registers 0, including frame_ready, key_valid, keys, acc_len, counters and sift_* operands.
- States: IDLE, ACCEPT, ISSUE, CHECK, OUTPUT.
- IDLE: if enable=1, go to ACCEPT next cycle.
- ACCEPT: frame_ready=1 (combinational from state only).
  - valid&ready at edge N: latch the four inputs into sift_* registers, increment frame_cnt, go to ISSUE.
  - enable=0 with no handshake: go to IDLE.
- ISSUE: one wait cycle; the sifter captures its operands at edge N+1. Go to CHECK.
- CHECK, sampling sifter outputs at edge N+2:
  - sift_s_len != sift_r_len: increment mismatch_cnt, accumulator unchanged, go to ACCEPT.
  - len=0: no change, go to ACCEPT.
  - Otherwise append compacted bits [len-1:0] at positions acc_len..acc_len+len-1 of both keys.
  - Bits of the sifter result at index >= len are don't-care and must be masked.
  - Bits that would land at index >= KEY_LEN are dropped; there is no carry-over into the next key.
  - acc_len = min(acc_len+len, KEY_LEN). If acc_len reaches KEY_LEN, go to OUTPUT, else go to ACCEPT.
- Throughput: at most one frame per 3 cycles. frame_ready is high again in the cycle after edge N+2.
- OUTPUT: key_valid=1; keys and acc_len held stable; frame_ready=0.
  - On key_ready=1 at an edge: clear keys and acc_len to 0, then go to ACCEPT if enable=1, else IDLE.
  - key_valid drops in the next cycle.
- enable is sampled only in IDLE, ACCEPT (no handshake) and on OUTPUT completion. A frame already accepted always completes CHECK.
- Counters saturate at all-ones; no wrap.
- Reset mid-operation discards the in-flight frame and the partial key immediately.

Decomposition:
- Shared package sift_pkg holds:
  - the FRAME_W and LEN_W constants;
  - the state enum (IDLE, ACCEPT, ISSUE, CHECK, OUTPUT);
  - KEY_LEN default.
- One natural sub-module: key_accum, the masked append/truncate shift-insert for one party, instantiated twice (sender and receiver).
- The FSM and counters stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-OUTPUT -> all outputs 0 immediately, state IDLE, key_valid=0 without any clock edge.
- Four frames, all svalid=all-ones, s_sifted=r_sifted=80'hA5..A5 -> acc_len 80/160/240/256. key_valid rises after the 4th CHECK. key bits [255:240] equal frame-4 bits [15:0]; frame-4 bits [79:16] are dropped. frame_cnt=4.
- Mismatch: s_svalid=80'hF, r_svalid=80'h7 -> mismatch_cnt=1, acc_len unchanged, frame_ready high 3 cycles after accept.
- Zero-length frame (both svalid=0) -> frame_cnt+1, acc_len and mismatch_cnt unchanged.
- Backpressure: hold key_ready=0 for 10 cycles in OUTPUT -> key_valid=1, keys stable, frame_ready=0 throughout. key_ready=1 -> acc_len=0, ACCEPT next cycle.
- enable dropped in the ISSUE cycle -> frame still appended, FSM returns to ACCEPT then IDLE. frame_ready=0 for as long as enable=0.
